// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, iteration counter width and the
// state encoding of the sequential shift-and-add multiplier.
//   WIDTH       operand width of the multiplier (fixed by adder_bit16)
//   CNT_W       iteration counter width, 2**CNT_W must exceed WIDTH
//   multState_t IDLE / RUN / DONE state encoding
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } multState_t;

endpackage

// File: rtl/adder_bit16.sv
// 16-bit ripple-carry adder, purely combinational.
//   aIn, bIn  16-bit addends
//   crIn      carry in
//   sumOut    16-bit sum
//   crOut     carry out of bit 15
module adder_bit16 (
  input  logic [15:0] aIn,
  input  logic [15:0] bIn,
  input  logic        crIn,
  output logic [15:0] sumOut,
  output logic        crOut
);

  logic [16:0] carry;

  assign carry[0] = crIn;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : gBit
      assign sumOut[gi]    = aIn[gi] ^ bIn[gi] ^ carry[gi];
      assign carry[gi + 1] = (aIn[gi] & bIn[gi]) | (carry[gi] & (aIn[gi] ^ bIn[gi]));
    end
  endgenerate

  assign crOut = carry[16];

endmodule

// File: rtl/mult_shift_add16.sv
// Sequential unsigned 16x16 -> 32-bit multiplier, radix-2 shift-and-add,
// one partial product per clock, valid/ready handshake on both sides.
//   clkIn        clock, all state on rising edge
//   rstNIn       asynchronous active-low reset
//   inValidIn    operands valid
//   inReadyOut   operands can be accepted (IDLE only)
//   aIn, bIn     multiplicand / multiplier, unsigned
//   outValidOut  prodOut valid (DONE)
//   outReadyIn   consumer accepts the product
//   prodOut      aIn*bIn, held until the next product is complete
//   busyOut      high in RUN and DONE
module mult_shift_add16
  import alu_pkg::*;
(
  input  logic        clkIn,
  input  logic        rstNIn,
  input  logic        inValidIn,
  output logic        inReadyOut,
  input  logic [15:0] aIn,
  input  logic [15:0] bIn,
  output logic        outValidOut,
  input  logic        outReadyIn,
  output logic [31:0] prodOut,
  output logic        busyOut
);

  multState_t               stateReg, stateNext;
  logic [CNT_W-1:0]         cntReg;
  logic [WIDTH-1:0]         mcandReg;
  // P[32:16] is the 17-bit accumulator (carry kept), P[15:0] the
  // multiplier bits still to be consumed.
  logic [2*WIDTH:0]         pReg;
  logic [2*WIDTH:0]         pNext;
  logic [2*WIDTH-1:0]       prodReg;
  logic [WIDTH:0]           accUpd;
  logic [WIDTH-1:0]         addSum;
  logic                     addCarry;
  logic                     accept;
  logic                     lastIter;

  adder_bit16 uAdd (
    .aIn    (pReg[2*WIDTH-1:WIDTH]),
    .bIn    (mcandReg),
    .crIn   (1'b0),
    .sumOut (addSum),
    .crOut  (addCarry)
  );

  // Add (when the current multiplier bit is 1) and shift happen as one
  // register update; the shift always clears P[32].
  always_comb begin
    accUpd = pReg[0] ? {addCarry, addSum} : pReg[2*WIDTH:WIDTH];
    pNext  = {accUpd, pReg[WIDTH-1:0]} >> 1;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) stateReg <= IDLE;
    else         stateReg <= stateNext;
  end

  always_comb begin
    stateNext   = stateReg;
    inReadyOut  = 1'b0;
    outValidOut = 1'b0;
    busyOut     = 1'b0;
    accept      = 1'b0;
    lastIter    = 1'b0;
    case (stateReg)
      IDLE: begin
        inReadyOut = 1'b1;
        if (inValidIn) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        busyOut = 1'b1;
        // Always the full WIDTH iterations, even for a zero multiplier.
        if (cntReg == CNT_W'(WIDTH - 1)) begin
          lastIter  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        busyOut     = 1'b1;
        outValidOut = 1'b1;
        if (outReadyIn) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operands are only sampled on an accepted handshake, so don't-care
  // values on aIn/bIn at other times never reach the datapath.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      cntReg   <= '0;
      mcandReg <= '0;
      pReg     <= '0;
      prodReg  <= '0;
    end else if (accept) begin
      cntReg   <= '0;
      mcandReg <= aIn;
      pReg     <= {{(WIDTH+1){1'b0}}, bIn};
    end else if (stateReg == RUN) begin
      cntReg <= cntReg + CNT_W'(1);
      pReg   <= pNext;
      // Separate result register keeps prodOut stable after the handshake
      // while the next operation reuses P.
      if (lastIter) prodReg <= pNext[2*WIDTH-1:0];
    end
  end

  assign prodOut = prodReg;

endmodule

// File: tb/tb_mult_shift_add16.sv
module tb_mult_shift_add16;

  logic        clkIn = 1'b0;
  logic        rstNIn;
  logic        inValidIn;
  logic        inReadyOut;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic        outValidOut;
  logic        outReadyIn;
  logic [31:0] prodOut;
  logic        busyOut;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] expProd;
    int          stall;
    string       tag;
  } vec_t;

  vec_t vecs[10];

  mult_shift_add16 dut (
    .clkIn       (clkIn),
    .rstNIn      (rstNIn),
    .inValidIn   (inValidIn),
    .inReadyOut  (inReadyOut),
    .aIn         (aIn),
    .bIn         (bIn),
    .outValidOut (outValidOut),
    .outReadyIn  (outReadyIn),
    .prodOut     (prodOut),
    .busyOut     (busyOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // One full transaction: accept, count latency, optional stall with
  // ignored operand pulses, handshake, then confirm return to IDLE.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [31:0] expProd,
                       input int stall, input bit noisy, input string tag);
    int waitC;
    int lat;
    waitC = 0;
    @(negedge clkIn);
    while (!inReadyOut && waitC < 50) begin
      @(negedge clkIn);
      waitC++;
    end
    check({tag, " inReady_idle"}, 64'(inReadyOut), 64'd1);
    inValidIn = 1'b1;
    aIn = a;
    bIn = b;
    @(posedge clkIn);
    lat = 1;
    @(negedge clkIn);
    inValidIn = 1'b0;
    aIn = 16'($urandom);
    bIn = 16'($urandom);
    check({tag, " busy_run"}, {62'd0, busyOut, inReadyOut}, 64'd2);
    while (!outValidOut && lat < 40) begin
      @(posedge clkIn);
      lat++;
      @(negedge clkIn);
    end
    check({tag, " latency"}, 64'(lat), 64'd17);
    check({tag, " prod"}, 64'(prodOut), 64'(expProd));
    for (int i = 0; i < stall; i++) begin
      if (noisy) begin
        inValidIn = 1'b1;
        aIn = 16'($urandom);
        bIn = 16'($urandom);
      end
      @(posedge clkIn);
      @(negedge clkIn);
      inValidIn = 1'b0;
      check({tag, " stall_hold"}, {31'd0, outValidOut, prodOut}, {31'd0, 1'b1, expProd});
    end
    outReadyIn = 1'b1;
    @(posedge clkIn);
    @(negedge clkIn);
    outReadyIn = 1'b0;
    check({tag, " post_handshake"}, {30'd0, outValidOut, inReadyOut, prodOut},
          {30'd0, 1'b0, 1'b1, expProd});
    $display("%s: a=0x%04h b=0x%04h prod=0x%08h exp=0x%08h lat=%0d stall=%0d",
             tag, a, b, prodOut, expProd, lat, stall);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{16'd3,     16'd5,     32'h0000000F, 0, "T1_basic"};
    vecs[1] = '{16'hFFFF,  16'hFFFF,  32'hFFFE0001, 1, "T2_carry"};
    vecs[2] = '{16'h8000,  16'h0002,  32'h00010000, 0, "T2_msb"};
    vecs[3] = '{16'h0000,  16'h1234,  32'h00000000, 0, "T3_a0"};
    vecs[4] = '{16'h1234,  16'h0000,  32'h00000000, 2, "T3_b0"};
    vecs[5] = '{16'h0001,  16'hFFFF,  32'h0000FFFF, 0, "V_one_a"};
    vecs[6] = '{16'hFFFF,  16'h0001,  32'h0000FFFF, 0, "V_one_b"};
    vecs[7] = '{16'h0100,  16'h0100,  32'h00010000, 0, "V_pow2"};
    vecs[8] = '{16'hABCD,  16'h0010,  32'h000ABCD0, 3, "V_shift"};
    vecs[9] = '{16'h8000,  16'h8000,  32'h40000000, 0, "V_top"};

    rstNIn     = 1'b0;
    inValidIn  = 1'b0;
    outReadyIn = 1'b0;
    aIn        = '0;
    bIn        = '0;
    repeat (3) @(negedge clkIn);
    check("reset_outputs", {29'd0, inReadyOut, outValidOut, busyOut, prodOut},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    rstNIn = 1'b1;
    @(negedge clkIn);
    check("after_release", {29'd0, inReadyOut, outValidOut, busyOut, prodOut},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});

    for (int i = 0; i < 10; i++)
      runOp(vecs[i].a, vecs[i].b, vecs[i].expProd, vecs[i].stall, 1'b0, vecs[i].tag);

    // Back-pressure with ignored operand pulses while DONE.
    runOp(16'd7, 16'd9, 32'h0000003F, 10, 1'b1, "T4_backpressure");

    // Reset in the middle of RUN.
    @(negedge clkIn);
    inValidIn = 1'b1;
    aIn = 16'h1234;
    bIn = 16'h5678;
    @(posedge clkIn);
    @(negedge clkIn);
    inValidIn = 1'b0;
    repeat (8) @(posedge clkIn);
    #2 rstNIn = 1'b0;
    #1;
    check("T5_async_reset", {29'd0, inReadyOut, outValidOut, busyOut, prodOut},
          {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clkIn);
    @(negedge clkIn);
    rstNIn = 1'b1;
    check("T5_idle_after", {30'd0, busyOut, outValidOut}, 64'd0);
    $display("T5_reset: aborted a=0x1234 b=0x5678 mid-RUN");
    runOp(16'd2, 16'd3, 32'd6, 0, 1'b0, "T5_after_reset");

    // Random operands with random stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 97 == 0) ra = 16'hFFFF;
      if (i % 89 == 0) rb = 16'h0000;
      runOp(ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "T6_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
